fp_operand_driver: RTL

Initiator for the two-operand/one-result strobe/acknowledge protocol used by the floating-point units (multiplier, adder, divider). It accepts an operand pair from an upstream command port, presents operands A and B to the arithmetic unit, collects result Z, and hands Z back upstream on a result port using the same protocol. It sits between the sequencing logic and any single-precision FP core, and optionally aborts transactions the core never completes.

---
 rtl/fp_operand_driver.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fp_operand_driver.sv
// fp_operand_driver: strobe/acknowledge initiator for a two-operand,
// one-result floating-point core. Takes an operand pair from the command
// port, hands A and B to the core, collects Z and presents it upstream.
// Optional abort of stalled core transactions: define FP_DRIVER_TIMEOUT_EN.
module fp_operand_driver #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic        cmd_stb,
  output logic        cmd_ack,
  output logic [31:0] output_a,
  output logic        output_a_stb,
  input  logic        output_a_ack,
  output logic [31:0] output_b,
  output logic        output_b_stb,
  input  logic        output_b_ack,
  input  logic [31:0] input_z,
  input  logic        input_z_stb,
  output logic        input_z_ack,
  output logic [31:0] result_z,
  output logic        result_err,
  output logic        result_stb,
  input  logic        result_ack
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_Z, PRESENT} state_t;

  state_t      state, state_n;
  logic        cmd_ack_n;
  logic [31:0] output_a_n, output_b_n, result_z_n;
  logic        output_a_stb_n, output_b_stb_n, input_z_ack_n;
  logic        result_err_n, result_stb_n;
  logic        a_xfer, b_xfer, z_xfer;

  assign a_xfer = output_a_stb && output_a_ack;
  assign b_xfer = output_b_stb && output_b_ack;
  assign z_xfer = input_z_stb && input_z_ack;

`ifdef FP_DRIVER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt, tmo_cnt_n;
  logic          tmo_hit, abort_now;

  assign tmo_hit = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`endif

  // Next-state and next-output logic; every register holds unless changed
  always_comb begin
    state_n        = state;
    cmd_ack_n      = cmd_ack;
    output_a_n     = output_a;
    output_b_n     = output_b;
    output_a_stb_n = output_a_stb;
    output_b_stb_n = output_b_stb;
    input_z_ack_n  = input_z_ack;
    result_z_n     = result_z;
    result_err_n   = result_err;
    result_stb_n   = result_stb;
`ifdef FP_DRIVER_TIMEOUT_EN
    tmo_cnt_n      = '0;
    abort_now      = 1'b0;
`endif
    case (state)
      IDLE: begin
        cmd_ack_n = 1'b1;
        if (cmd_stb && cmd_ack) begin
          output_a_n     = cmd_a;
          output_b_n     = cmd_b;
          cmd_ack_n      = 1'b0;
          output_a_stb_n = 1'b1;
          output_b_stb_n = 1'b1;
          state_n        = SEND;
        end
      end
      SEND: begin
        output_a_stb_n = output_a_stb && !a_xfer;
        output_b_stb_n = output_b_stb && !b_xfer;
        if (!output_a_stb_n && !output_b_stb_n) begin
          input_z_ack_n = 1'b1;
          state_n       = WAIT_Z;
        end
`ifdef FP_DRIVER_TIMEOUT_EN
        else if (a_xfer || b_xfer)
          tmo_cnt_n = '0;
        else if (tmo_hit)
          abort_now = 1'b1;
        else
          tmo_cnt_n = tmo_cnt + 1'b1;
`endif
      end
      WAIT_Z: begin
        if (z_xfer) begin
          result_z_n    = input_z;
          result_err_n  = 1'b0;
          input_z_ack_n = 1'b0;
          result_stb_n  = 1'b1;
          state_n       = PRESENT;
        end
`ifdef FP_DRIVER_TIMEOUT_EN
        else if (tmo_hit)
          abort_now = 1'b1;
        else
          tmo_cnt_n = tmo_cnt + 1'b1;
`endif
      end
      PRESENT: begin
        if (result_stb && result_ack) begin
          result_stb_n = 1'b0;
          state_n      = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
`ifdef FP_DRIVER_TIMEOUT_EN
    if (abort_now) begin
      output_a_stb_n = 1'b0;
      output_b_stb_n = 1'b0;
      input_z_ack_n  = 1'b0;
      result_z_n     = 32'h7FC0_0000;
      result_err_n   = 1'b1;
      result_stb_n   = 1'b1;
      state_n        = PRESENT;
    end
`endif
  end

  // State and output registers; reset clears everything mid-transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cmd_ack      <= 1'b0;
      output_a     <= '0;
      output_b     <= '0;
      output_a_stb <= 1'b0;
      output_b_stb <= 1'b0;
      input_z_ack  <= 1'b0;
      result_z     <= '0;
      result_err   <= 1'b0;
      result_stb   <= 1'b0;
    end else begin
      state        <= state_n;
      cmd_ack      <= cmd_ack_n;
      output_a     <= output_a_n;
      output_b     <= output_b_n;
      output_a_stb <= output_a_stb_n;
      output_b_stb <= output_b_stb_n;
      input_z_ack  <= input_z_ack_n;
      result_z     <= result_z_n;
      result_err   <= result_err_n;
      result_stb   <= result_stb_n;
    end
  end

`ifdef FP_DRIVER_TIMEOUT_EN
  // Stall counter, restarted on state entry and on each operand handshake
  always_ff @(posedge clk) begin
    if (rst)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt_n;
  end
`endif

endmodule
